// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host controller: enables data reporting after reset, then tracks
// an absolute, clamped X/Y cursor position from 3-byte movement packets and
// exposes it to the CPU as two read-only 10-bit registers.
module ps2_mouse_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_cs,
  input  logic       addr,
  output logic [9:0] data,
  output logic       RDA,
  output logic       t_clk,
  inout  logic       MOUSE_CLOCK,
  inout  logic       MOUSE_DATA
);

  typedef enum logic [2:0] {
    S_INHIBIT,
    S_REQ,
    S_TX,
    S_TX_ACK,
    S_WAIT_ACK,
    S_STREAM
  } state_t;

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] REQ_LAST = CW'(1);

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  // stop, odd parity, data (LSB shifted out first)
  localparam logic [9:0] TX_FRAME   = {1'b1, ~^CMD_ENABLE, CMD_ENABLE};

  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
  localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);
  localparam logic [9:0]         XMAX_V = 10'(X_MAX);
  localparam logic [9:0]         YMAX_V = 10'(Y_MAX);
  localparam logic [9:0]         XINI_V = 10'(X_INIT);
  localparam logic [9:0]         YINI_V = 10'(Y_INIT);

  state_t          state_q, state_d;
  logic            t_clk_q, t_clk_d;
  logic            dat_oe_q, dat_oe_d;

  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;
  logic            fall;
  logic            rx_en;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   gap_q, gap_d;

  logic [9:0]      tx_sr_q, tx_sr_d;
  logic            tx_bit_q, tx_bit_d;
  logic [3:0]      tx_cnt_q, tx_cnt_d;

  logic [3:0]      rx_cnt_q, rx_cnt_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic            rx_par_q, rx_par_d;
  logic            byte_vld;
  logic            rx_abort;

  logic [1:0]      idx_q, idx_d;
  logic [3:0]      flags_q, flags_d;   // {y_ovf, x_ovf, y_sign, x_sign}
  logic [7:0]      dx_q, dx_d;
  logic [7:0]      dy_q, dy_d;
  logic            upd_q, upd_d;

  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            rda_q, rda_d;
  logic signed [11:0] x_sum, y_sum;

  assign fall  = clk_prev_q & ~clk_sync_q;
  assign rx_en = (state_q == S_WAIT_ACK) || (state_q == S_STREAM);

  assign MOUSE_CLOCK = t_clk_q  ? 1'b0 : 1'bz;
  assign MOUSE_DATA  = dat_oe_q ? 1'b0 : 1'bz;
  assign t_clk = t_clk_q;
  assign RDA   = rda_q;
  assign data  = addr ? y_q : x_q;

  // FSM state register; line drivers are registered from the next state so
  // that reset holds both lines released and t_clk low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_INHIBIT;
      t_clk_q  <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_clk_q  <= t_clk_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  // FSM next-state logic for the enable handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INHIBIT:  if (cnt_q == INH_LAST) state_d = S_REQ;
      S_REQ:      if (cnt_q == REQ_LAST) state_d = S_TX;
      S_TX:       if (fall && (tx_cnt_q == 4'd9)) state_d = S_TX_ACK;
      S_TX_ACK:   if (fall) state_d = dat_sync_q ? S_INHIBIT : S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (byte_vld && (rx_sr_q == RSP_ACK)) state_d = S_STREAM;
        else if (cnt_q == TO_LAST)            state_d = S_INHIBIT;
      end
      S_STREAM:   state_d = S_STREAM;
      default:    state_d = S_INHIBIT;
    endcase
  end

  // FSM outputs: clock held low in INHIBIT/REQ, data low for each 0 bit sent
  always_comb begin
    t_clk_d  = (state_d == S_INHIBIT) || (state_d == S_REQ);
    dat_oe_d = ((state_d == S_REQ) || (state_d == S_TX)) && !tx_bit_d;
  end

  // Line synchronizers and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      cnt_q      <= '0;
      gap_q      <= '0;
      tx_sr_q    <= TX_FRAME;
      tx_bit_q   <= 1'b0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      rx_par_q   <= 1'b0;
      idx_q      <= '0;
      flags_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      upd_q      <= 1'b0;
      x_q        <= XINI_V;
      y_q        <= YINI_V;
      rda_q      <= 1'b0;
    end else begin
      clk_meta_q <= MOUSE_CLOCK;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= MOUSE_DATA;
      dat_sync_q <= dat_meta_q;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tx_sr_q    <= tx_sr_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_par_q   <= rx_par_d;
      idx_q      <= idx_d;
      flags_q    <= flags_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      upd_q      <= upd_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rda_q      <= rda_d;
    end
  end

  // State timer and host-to-device shifter (next bit presented on each falling edge)
  always_comb begin
    cnt_d    = '0;
    tx_sr_d  = tx_sr_q;
    tx_bit_d = tx_bit_q;
    tx_cnt_d = tx_cnt_q;
    if ((state_d == state_q) &&
        ((state_q == S_INHIBIT) || (state_q == S_REQ) || (state_q == S_WAIT_ACK)))
      cnt_d = cnt_q + 1'b1;
    if (state_q == S_INHIBIT) begin
      tx_sr_d  = TX_FRAME;
      tx_bit_d = 1'b0;
      tx_cnt_d = '0;
    end else if ((state_q == S_TX) && fall) begin
      tx_bit_d = tx_sr_q[0];
      tx_sr_d  = {1'b1, tx_sr_q[9:1]};
      tx_cnt_d = tx_cnt_q + 4'd1;
    end
  end

  // Device-to-host frame receiver with inter-edge gap timeout
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    rx_sr_d  = rx_sr_q;
    rx_par_d = rx_par_q;
    gap_d    = gap_q;
    byte_vld = 1'b0;
    rx_abort = 1'b0;
    if (!rx_en) begin
      rx_cnt_d = '0;
      gap_d    = '0;
    end else if (fall) begin
      gap_d = '0;
      if (rx_cnt_q == 4'd0) begin
        if (!dat_sync_q) rx_cnt_d = 4'd1;
      end else if (rx_cnt_q <= 4'd8) begin
        rx_sr_d  = {dat_sync_q, rx_sr_q[7:1]};
        rx_cnt_d = rx_cnt_q + 4'd1;
      end else if (rx_cnt_q == 4'd9) begin
        rx_par_d = dat_sync_q;
        rx_cnt_d = 4'd10;
      end else begin
        rx_cnt_d = '0;
        if (dat_sync_q && (^{rx_par_q, rx_sr_q})) byte_vld = 1'b1;
        else                                      rx_abort = 1'b1;
      end
    end else if (rx_cnt_q != 4'd0) begin
      if (gap_q == GAP_MAX) begin
        rx_cnt_d = '0;
        gap_d    = '0;
        rx_abort = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // Packet assembly: byte0 must carry bit3=1 to start a packet
  always_comb begin
    idx_d   = idx_q;
    flags_d = flags_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    upd_d   = 1'b0;
    if (state_q == S_STREAM) begin
      if (rx_abort) begin
        idx_d = '0;
      end else if (byte_vld) begin
        case (idx_q)
          2'd0: if (rx_sr_q[3]) begin
            flags_d = rx_sr_q[7:4];
            idx_d   = 2'd1;
          end
          2'd1: begin
            dx_d  = rx_sr_q;
            idx_d = 2'd2;
          end
          2'd2: begin
            dy_d  = rx_sr_q;
            idx_d = 2'd0;
            upd_d = 1'b1;
          end
          default: idx_d = '0;
        endcase
      end
    end
  end

  // Clamped position update and RDA (a new sample wins over a Y read)
  always_comb begin
    x_sum = $signed({2'b00, x_q}) + $signed({{4{flags_q[0]}}, dx_q});
    y_sum = $signed({2'b00, y_q}) - $signed({{4{flags_q[1]}}, dy_q});
    x_d   = x_q;
    y_d   = y_q;
    rda_d = rda_q;
    if (io_cs && addr) rda_d = 1'b0;
    if (upd_q) begin
      rda_d = 1'b1;
      if (!flags_q[2]) begin
        if (x_sum < 12'sd0)       x_d = '0;
        else if (x_sum > XMAX_S)  x_d = XMAX_V;
        else                      x_d = x_sum[9:0];
      end
      if (!flags_q[3]) begin
        if (y_sum < 12'sd0)       y_d = '0;
        else if (y_sum > YMAX_S)  y_d = YMAX_V;
        else                      y_d = y_sum[9:0];
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: models the mouse side of the PS/2 bus,
// checks the 0xF4 enable transfer, ACK timeout retry, and cursor arithmetic.
module tb_ps2_mouse_ctrl;

  localparam int INH = 40;
  localparam int TO  = 1000;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       io_cs = 1'b0;
  logic       addr = 1'b0;
  logic [9:0] data;
  logic       RDA;
  logic       t_clk;
  wire        ms_clk;
  wire        ms_dat;
  logic       dev_clk_lo = 1'b0;
  logic       dev_dat_lo = 1'b0;

  int unsigned cyc = 0;
  int unsigned ack_end_cyc = 0;
  int unsigned tclk_rise_cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  assign ms_clk = dev_clk_lo ? 1'b0 : 1'bz;
  assign ms_dat = dev_dat_lo ? 1'b0 : 1'bz;
  pullup (ms_clk);
  pullup (ms_dat);

  ps2_mouse_ctrl #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .X_MAX(639),
    .Y_MAX(479),
    .X_INIT(320),
    .Y_INIT(240)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_cs(io_cs),
    .addr(addr),
    .data(data),
    .RDA(RDA),
    .t_clk(t_clk),
    .MOUSE_CLOCK(ms_clk),
    .MOUSE_DATA(ms_dat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dev_bit(input logic b);
    dev_dat_lo = ~b;
    ticks(H / 2);
    dev_clk_lo = 1'b1;
    ticks(H);
    dev_clk_lo = 1'b0;
    ticks(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) dev_bit(fr[i]);
    dev_dat_lo = 1'b0;
    ticks(H);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    ticks(4);
  endtask

  task automatic check_pos(input string t, input int x, input int y, input logic r);
    logic [9:0] v;
    addr = 1'b0; #1; v = data;
    check($sformatf("%s_x", t), 32'(v), 32'(x));
    addr = 1'b1; #1; v = data;
    check($sformatf("%s_y", t), 32'(v), 32'(y));
    addr = 1'b0;
    check($sformatf("%s_rda", t), 32'(RDA), 32'(r));
  endtask

  task automatic clear_rda();
    io_cs = 1'b1;
    addr  = 1'b1;
    ticks(1);
    io_cs = 1'b0;
    addr  = 1'b0;
  endtask

  // Host inhibit/request followed by the mouse clocking out 0xF4 and ACKing it
  task automatic handshake(input string t);
    int n;
    logic [9:0] fr;
    n = 0;
    while (t_clk !== 1'b1 && n < 3000) begin ticks(1); n++; end
    tclk_rise_cyc = cyc;
    check({t, "_inhibit"}, 32'(t_clk), 1);
    check({t, "_clk_low"}, 32'(ms_clk), 0);
    n = 0;
    while (t_clk === 1'b1 && n < 3000) begin ticks(1); n++; end
    check({t, "_inhibit_len_ok"}, 32'((n >= INH + 1) && (n <= INH + 2)), 1);
    check({t, "_start_bit"}, 32'(ms_dat), 0);
    check({t, "_clk_released"}, 32'(ms_clk), 1);
    ticks(H);
    for (int i = 0; i < 10; i++) begin
      dev_clk_lo = 1'b1;
      ticks(H);
      fr[i] = ms_dat;
      dev_clk_lo = 1'b0;
      ticks(H);
    end
    check({t, "_tx_byte"}, 32'(fr[7:0]), 32'h0F4);
    check({t, "_tx_parity"}, 32'(fr[8]), 0);
    check({t, "_tx_stop"}, 32'(fr[9]), 1);
    dev_dat_lo = 1'b1;
    ticks(H / 2);
    dev_clk_lo = 1'b1;
    ticks(H);
    dev_clk_lo = 1'b0;
    ticks(H / 2);
    dev_dat_lo = 1'b0;
    ticks(H);
    ack_end_cyc = cyc;
  endtask

  initial begin
    int unsigned prev_ack;
    int unsigned d;

    ticks(3);
    check("rst_tclk", 32'(t_clk), 0);
    check("rst_clk_line", 32'(ms_clk), 1);
    check("rst_dat_line", 32'(ms_dat), 1);
    check_pos("rst", 320, 240, 1'b0);

    rst = 1'b1;
    handshake("hs1");
    send_byte(8'hAA, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFA, 1'b0);
    ticks(4);
    check_pos("stream", 320, 240, 1'b0);
    check("stream_tclk", 32'(t_clk), 0);

    send_pkt(8'h08, 8'h0A, 8'h05);
    check_pos("p1", 330, 235, 1'b1);
    clear_rda();
    check("rda_clear", 32'(RDA), 0);

    send_pkt(8'h18, 8'h00, 8'h00);
    check_pos("xneg1", 74, 235, 1'b1);
    send_pkt(8'h18, 8'h00, 8'h00);
    check_pos("xneg2", 0, 235, 1'b1);
    send_pkt(8'h28, 8'h00, 8'h00);
    check_pos("yneg1", 0, 479, 1'b1);
    send_pkt(8'h28, 8'h00, 8'h00);
    check_pos("yneg2", 0, 479, 1'b1);
    clear_rda();

    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    send_byte(8'h07, 1'b0);
    ticks(4);
    check_pos("badpar", 0, 479, 1'b0);
    send_pkt(8'h08, 8'h03, 8'h02);
    check_pos("resync", 3, 477, 1'b1);

    send_pkt(8'h48, 8'h10, 8'h10);
    check_pos("xovf", 3, 461, 1'b1);
    send_pkt(8'h18, 8'hFE, 8'h00);
    check_pos("xm2", 1, 461, 1'b1);
    send_pkt(8'h08, 8'h00, 8'hFF);
    check_pos("ydn1", 1, 206, 1'b1);
    send_pkt(8'h08, 8'h00, 8'hFF);
    check_pos("ydn2", 1, 0, 1'b1);
    send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h08, 8'hFF, 8'h00);
    check_pos("xup2", 511, 0, 1'b1);
    send_pkt(8'h08, 8'hFF, 8'h00);
    check_pos("xup3", 639, 0, 1'b1);

    send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b0);
    rst = 1'b0;
    ticks(2);
    check_pos("midrst", 320, 240, 1'b0);
    check("midrst_tclk", 32'(t_clk), 0);
    rst = 1'b1;

    handshake("hs2");
    send_byte(8'hAA, 1'b0);
    prev_ack = ack_end_cyc;
    handshake("hs3");
    d = tclk_rise_cyc - prev_ack;
    check("ack_timeout_window", 32'((d >= TO - 3 * H) && (d <= TO)), 1);
    send_byte(8'hFA, 1'b0);
    ticks(4);
    send_pkt(8'h08, 8'h01, 8'h01);
    check_pos("post_rst", 321, 239, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
PS/2 host controller for a standard 3-byte-packet mouse, mapped as a small read-only I/O peripheral. After reset it sends Enable Data Reporting (0xF4) to the mouse and waits for the 0xFA acknowledge. It then receives movement packets and keeps absolute, clamped X/Y cursor coordinates. The CPU reads those coordinates over a 10-bit data bus selected by io_cs/addr.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds MOUSE_CLOCK low before a host-to-device transfer (≥100 us at the system clock rate)
TIMEOUT_CYCLES, 100000, max clk cycles between PS/2 clock falling edges inside a frame, and max wait for the 0xFA response
X_MAX, 639, maximum X coordinate
Y_MAX, 479, maximum Y coordinate
X_INIT, 320, X coordinate after reset
Y_INIT, 240, Y coordinate after reset

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-low reset
io_cs  in  1  peripheral select (read strobe)
addr  in  1  register select: 0 = X, 1 = Y
data  out  10  addr=0 -> X position; addr=1 -> Y position; unsigned
RDA  out  1  new position available
t_clk  out  1  1 = host owns MOUSE_CLOCK (driving it low); the device must release the line while t_clk=1
MOUSE_CLOCK  inout  1  PS/2 clock; open-collector (drive 0 or z; external pull-up)
MOUSE_DATA  inout  1  PS/2 data; open-collector

Behaviour:
- Reset (rst=0 at clk edge):
  - state=INHIBIT, counters cleared.
  - X=X_INIT, Y=Y_INIT, RDA=0, t_clk=0.
  - Both lines released (z).
- MOUSE_CLOCK and MOUSE_DATA pass through 2-flop synchronizers. A falling edge means sync'd clock was 1 and is now 0.
- data is a combinational mux on addr and is valid regardless of io_cs.
- RDA:
  - Set when a valid packet updates X/Y.
  - Cleared on a clk edge with io_cs=1 and addr=1 (reading Y completes the pair).
  - If set and clear coincide, set wins.
- Init FSM:
  - INHIBIT: t_clk=1, drive MOUSE_CLOCK=0 for INHIBIT_CYCLES.
  - REQ: drive MOUSE_DATA=0 (start bit), hold one more cycle, then release the clock (t_clk=0).
  - TX: on each device falling edge, present the next bit: 8 data bits of 0xF4 LSB first, then odd parity, then stop (release data = 1).
  - TX_ACK: wait for a falling edge. Sampled data 0 -> WAIT_ACK; 1 -> INHIBIT (retry).
  - WAIT_ACK: receive bytes (receiver below).
    - 0xFA -> STREAM.
    - Any other byte (e.g. 0xAA, 0x00) is ignored.
    - TIMEOUT_CYCLES without 0xFA -> INHIBIT (retry).
  - STREAM: remains here until reset.
- Receiver (device-to-host):
  - Frame = start(0), 8 data LSB first, odd parity, stop(1); each bit sampled on a falling edge.
  - Start bit =1 -> ignore that edge.
  - Parity or stop error -> discard the byte and reset packet byte index to 0.
  - Gap > TIMEOUT_CYCLES mid-frame -> abort the frame and reset packet byte index.
- Packet handling in STREAM:
  - Byte0 flags: [7] Y overflow, [6] X overflow, [5] Y sign, [4] X sign, [3] always 1, [2:0] buttons.
  - Byte0 with bit3=0 -> discard, stay at index 0 (resync).
  - Byte1 = dX[7:0], byte2 = dY[7:0].
  - dX = {Xsign, byte1} and dY = {Ysign, byte2}, each 9-bit two's complement.
- Position update, one clk after byte2 is accepted:
  - X = clamp(X + dX, 0, X_MAX).
  - Y = clamp(Y − dY, 0, Y_MAX); mouse up = screen Y decreasing.
  - An axis with its overflow bit set is left unchanged.
  - Arithmetic is done in ≥12-bit signed; below 0 saturates to 0, above max saturates to max.
  - RDA set in the same cycle.
- Buttons are decoded but not exposed.
- Host never drives MOUSE_CLOCK outside INHIBIT/REQ. MOUSE_DATA is driven only in REQ/TX.

Test Plan:
- Reset then release: t_clk=1 and MOUSE_CLOCK=0 for INHIBIT_CYCLES. Then MOUSE_DATA=0 and t_clk=0. Bench clocks 11 edges and sees bits 0,0,0,1,0,1,1,1,1 (F4 LSB first), parity 0, stop 1. Bench drives ACK=0.
- Bench sends 0xAA, 0x00, 0xFA -> FSM reaches STREAM. Reads give X=320, Y=240, RDA=0.
- Packet 0x08, 0x0A, 0x05 -> RDA=1, X=330, Y=235. Read addr=1 with io_cs=1 -> RDA=0.
- Packet 0x18, 0x00 (dX=−256) twice -> X saturates to 0. Packet 0x28, 0x00, 0x00 (dY=−256) twice -> Y saturates to 479.
- Byte with bad parity inside a packet -> no update. The next good 3-byte packet updates correctly. Byte0 with bit3=0 is discarded.
- No 0xFA within TIMEOUT_CYCLES -> FSM re-enters INHIBIT (t_clk=1) and resends 0xF4. rst=0 mid-packet -> X/Y reinitialised and byte index cleared.
